stg_mo: RTL and testbench

//  Pipeline stage 6 (memory operation), directly downstream of stg_ma. MO performs the load/store
//  on the dual-port memory port selected by iw_mem_mp. The address on that port was set by MA one

---
 rtl/stg_mo_pkg.sv | 34 +++
 rtl/stg_mo_opc_class.sv | 31 +++
 rtl/stg_mo.sv | 228 ++++++++++++++++++++++
 tb/tb_stg_mo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/stg_mo_pkg.sv
// Shared definitions for the memory-operation stage: opcode map, access classes, FSM states.
// Wide words are little-endian by word: low half at A, high half at A+1.
package stg_mo_pkg;

    localparam int MO_DATA_W = 24;
    localparam int MO_ADDR_W = 48;
    localparam int OPC_W     = 6;
    localparam int GP_W      = 4;
    localparam int SR_W      = 2;
    localparam int AR_W      = 2;

    localparam logic [OPC_W-1:0] OPC_NOP    = 6'h00;
    localparam logic [OPC_W-1:0] OPC_LD     = 6'h10;
    localparam logic [OPC_W-1:0] OPC_ST     = 6'h11;
    localparam logic [OPC_W-1:0] OPC_LDW_SR = 6'h12;
    localparam logic [OPC_W-1:0] OPC_LDW_AR = 6'h13;
    localparam logic [OPC_W-1:0] OPC_STW_SR = 6'h14;
    localparam logic [OPC_W-1:0] OPC_STW_AR = 6'h15;

    typedef enum logic [2:0] {
        MO_CLS_NONE = 3'd0,
        MO_CLS_LD   = 3'd1,
        MO_CLS_ST   = 3'd2,
        MO_CLS_LDW  = 3'd3,
        MO_CLS_STW  = 3'd4
    } mo_cls_t;

    typedef enum logic [1:0] {
        MO_S_PASS    = 2'd0,
        MO_S_HI_ADDR = 2'd1,
        MO_S_HI_DATA = 2'd2
    } mo_state_t;

endpackage

// File: rtl/stg_mo_opc_class.sv
// Opcode -> memory access class, plus whether a wide access uses the AR or SR result.
// Purely combinational, no latency, no flow control; also consumed by hazard logic.
module mo_opc_class
    import stg_mo_pkg::*;
(
    input  logic [OPC_W-1:0] iw_opc,
    output logic [2:0]       ow_cls,
    output logic             ow_sel_ar
);

    always_comb begin
        ow_cls    = MO_CLS_NONE;
        ow_sel_ar = 1'b0;
        case (iw_opc)
            OPC_LD:     ow_cls = MO_CLS_LD;
            OPC_ST:     ow_cls = MO_CLS_ST;
            OPC_LDW_SR: ow_cls = MO_CLS_LDW;
            OPC_LDW_AR: begin
                ow_cls    = MO_CLS_LDW;
                ow_sel_ar = 1'b1;
            end
            OPC_STW_SR: ow_cls = MO_CLS_STW;
            OPC_STW_AR: begin
                ow_cls    = MO_CLS_STW;
                ow_sel_ar = 1'b1;
            end
            default: ow_cls = MO_CLS_NONE;
        endcase
    end

endmodule

// File: rtl/stg_mo.sv
// Memory-operation stage: narrow load/store in one cycle, wide ops as lo/addr/hi beats.
// Latency 1 cycle (wide 3); ow_stall holds upstream 2 cycles for wide ops.
// MO_ALIGN_CHECK_EN: misaligned wide access faults in 1 cycle instead of accessing memory.
module stg_mo
    import stg_mo_pkg::*;
#(
    parameter int DATA_W = MO_DATA_W,
    parameter int ADDR_W = MO_ADDR_W
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic [ADDR_W-1:0] iw_pc,
    input  logic [DATA_W-1:0] iw_instr,
    input  logic [OPC_W-1:0]  iw_opc,
    input  logic [OPC_W-1:0]  iw_root_opc,
    input  logic [GP_W-1:0]   iw_tgt_gp,
    input  logic              iw_tgt_gp_we,
    input  logic [SR_W-1:0]   iw_tgt_sr,
    input  logic              iw_tgt_sr_we,
    input  logic [AR_W-1:0]   iw_tgt_ar,
    input  logic              iw_tgt_ar_we,
    input  logic [DATA_W-1:0] iw_result,
    input  logic [ADDR_W-1:0] iw_sr_result,
    input  logic [ADDR_W-1:0] iw_ar_result,
    input  logic [ADDR_W-1:0] iw_addr_q,
    input  logic              iw_mem_mp,
    output logic [1:0]        ow_mem_we,
    output logic [DATA_W-1:0] ow_mem_wdata [0:1],
    input  logic [DATA_W-1:0] iw_mem_rdata [0:1],
    output logic [ADDR_W-1:0] ow_mem_addr_ovr,
    output logic              ow_mem_addr_ovr_en,
    output logic              ow_stall,
    output logic [ADDR_W-1:0] ow_pc,
    output logic [DATA_W-1:0] ow_instr,
    output logic [OPC_W-1:0]  ow_opc,
    output logic [OPC_W-1:0]  ow_root_opc,
    output logic [GP_W-1:0]   ow_tgt_gp,
    output logic              ow_tgt_gp_we,
    output logic [SR_W-1:0]   ow_tgt_sr,
    output logic              ow_tgt_sr_we,
    output logic [AR_W-1:0]   ow_tgt_ar,
    output logic              ow_tgt_ar_we,
    output logic [DATA_W-1:0] ow_result,
    output logic [ADDR_W-1:0] ow_sr_result,
    output logic [ADDR_W-1:0] ow_ar_result,
    output logic              ow_mem_fault
);

    logic [2:0]  cls;
    logic        sel_ar;
    logic        is_wide;
    logic        misalign;
    logic        start_wide;
    mo_state_t   state;
    mo_state_t   state_nxt;

    logic [DATA_W-1:0] rd_word;
    logic [ADDR_W-1:0] wide_src;
    logic              mem_go;
    logic [DATA_W-1:0] wdata_sel;

    logic [ADDR_W-1:0] cap_pc;
    logic [DATA_W-1:0] cap_instr;
    logic [OPC_W-1:0]  cap_opc;
    logic [OPC_W-1:0]  cap_root_opc;
    logic [GP_W-1:0]   cap_tgt_gp;
    logic              cap_tgt_gp_we;
    logic [SR_W-1:0]   cap_tgt_sr;
    logic              cap_tgt_sr_we;
    logic [AR_W-1:0]   cap_tgt_ar;
    logic              cap_tgt_ar_we;
    logic [DATA_W-1:0] cap_result;
    logic [ADDR_W-1:0] cap_sr_result;
    logic [ADDR_W-1:0] cap_ar_result;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_lo;
    logic              cap_is_ld;
    logic              cap_sel_ar;

    mo_opc_class u_opc_class (
        .iw_opc    (iw_opc),
        .ow_cls    (cls),
        .ow_sel_ar (sel_ar)
    );

    assign is_wide  = (cls == MO_CLS_LDW) || (cls == MO_CLS_STW);
`ifdef MO_ALIGN_CHECK_EN
    assign misalign = is_wide & iw_addr_q[0];
`else
    assign misalign = 1'b0;
`endif
    assign start_wide = is_wide & ~misalign;
    assign rd_word    = iw_mem_mp ? iw_mem_rdata[1] : iw_mem_rdata[0];
    assign wide_src   = sel_ar ? iw_ar_result : iw_sr_result;

    always_ff @(posedge iw_clk) begin
        if (iw_rst) state <= MO_S_PASS;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            MO_S_PASS:    if (start_wide) state_nxt = MO_S_HI_ADDR;
            MO_S_HI_ADDR: state_nxt = MO_S_HI_DATA;
            MO_S_HI_DATA: state_nxt = MO_S_PASS;
            default:      state_nxt = MO_S_PASS;
        endcase
    end

    // Memory strobes are suppressed under reset so an aborted wide store never lands its hi beat.
    always_comb begin
        mem_go             = 1'b0;
        wdata_sel          = '0;
        ow_mem_addr_ovr    = '0;
        ow_mem_addr_ovr_en = 1'b0;
        ow_stall           = 1'b0;
        unique case (state)
            MO_S_PASS: begin
                ow_stall = start_wide;
                if (cls == MO_CLS_ST) begin
                    mem_go    = 1'b1;
                    wdata_sel = iw_result;
                end else if (cls == MO_CLS_STW && !misalign) begin
                    mem_go    = 1'b1;
                    wdata_sel = wide_src[DATA_W-1:0];
                end
            end
            MO_S_HI_ADDR: begin
                ow_stall           = 1'b1;
                ow_mem_addr_ovr    = cap_addr + ADDR_W'(1);
                ow_mem_addr_ovr_en = 1'b1;
            end
            MO_S_HI_DATA: begin
                mem_go    = ~cap_is_ld;
                wdata_sel = cap_sel_ar ? cap_ar_result[ADDR_W-1:DATA_W]
                                       : cap_sr_result[ADDR_W-1:DATA_W];
            end
            default: mem_go = 1'b0;
        endcase
        if (iw_rst) begin
            mem_go   = 1'b0;
            ow_stall = 1'b0;
        end
        ow_mem_we       = {mem_go & iw_mem_mp, mem_go & ~iw_mem_mp};
        ow_mem_wdata[0] = ow_mem_we[0] ? wdata_sel : '0;
        ow_mem_wdata[1] = ow_mem_we[1] ? wdata_sel : '0;
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            ow_pc <= '0; ow_instr <= '0; ow_opc <= '0; ow_root_opc <= '0;
            ow_tgt_gp <= '0; ow_tgt_gp_we <= 1'b0;
            ow_tgt_sr <= '0; ow_tgt_sr_we <= 1'b0;
            ow_tgt_ar <= '0; ow_tgt_ar_we <= 1'b0;
            ow_result <= '0; ow_sr_result <= '0; ow_ar_result <= '0;
            ow_mem_fault <= 1'b0;
            cap_pc <= '0; cap_instr <= '0; cap_opc <= '0; cap_root_opc <= '0;
            cap_tgt_gp <= '0; cap_tgt_gp_we <= 1'b0;
            cap_tgt_sr <= '0; cap_tgt_sr_we <= 1'b0;
            cap_tgt_ar <= '0; cap_tgt_ar_we <= 1'b0;
            cap_result <= '0; cap_sr_result <= '0; cap_ar_result <= '0;
            cap_addr <= '0; cap_lo <= '0; cap_is_ld <= 1'b0; cap_sel_ar <= 1'b0;
        end else begin
            unique case (state)
                MO_S_PASS: begin
                    ow_pc        <= iw_pc;
                    ow_instr     <= iw_instr;
                    ow_opc       <= iw_opc;
                    ow_root_opc  <= iw_root_opc;
                    ow_tgt_gp    <= iw_tgt_gp;
                    ow_tgt_sr    <= iw_tgt_sr;
                    ow_tgt_ar    <= iw_tgt_ar;
                    ow_tgt_gp_we <= iw_tgt_gp_we & ~is_wide;
                    ow_tgt_sr_we <= iw_tgt_sr_we & ~is_wide;
                    ow_tgt_ar_we <= iw_tgt_ar_we & ~is_wide;
                    ow_result    <= (cls == MO_CLS_LD) ? rd_word : iw_result;
                    ow_sr_result <= iw_sr_result;
                    ow_ar_result <= iw_ar_result;
                    ow_mem_fault <= misalign;
                    if (start_wide) begin
                        cap_pc        <= iw_pc;
                        cap_instr     <= iw_instr;
                        cap_opc       <= iw_opc;
                        cap_root_opc  <= iw_root_opc;
                        cap_tgt_gp    <= iw_tgt_gp;
                        cap_tgt_gp_we <= iw_tgt_gp_we;
                        cap_tgt_sr    <= iw_tgt_sr;
                        cap_tgt_sr_we <= iw_tgt_sr_we;
                        cap_tgt_ar    <= iw_tgt_ar;
                        cap_tgt_ar_we <= iw_tgt_ar_we;
                        cap_result    <= iw_result;
                        cap_sr_result <= iw_sr_result;
                        cap_ar_result <= iw_ar_result;
                        cap_addr      <= iw_addr_q;
                        cap_lo        <= rd_word;
                        cap_is_ld     <= (cls == MO_CLS_LDW);
                        cap_sel_ar    <= sel_ar;
                    end
                end
                MO_S_HI_ADDR: begin
                    ow_tgt_gp_we <= 1'b0;
                    ow_tgt_sr_we <= 1'b0;
                    ow_tgt_ar_we <= 1'b0;
                    ow_mem_fault <= 1'b0;
                end
                MO_S_HI_DATA: begin
                    ow_pc        <= cap_pc;
                    ow_instr     <= cap_instr;
                    ow_opc       <= cap_opc;
                    ow_root_opc  <= cap_root_opc;
                    ow_tgt_gp    <= cap_tgt_gp;
                    ow_tgt_gp_we <= cap_tgt_gp_we;
                    ow_tgt_sr    <= cap_tgt_sr;
                    ow_tgt_sr_we <= cap_tgt_sr_we;
                    ow_tgt_ar    <= cap_tgt_ar;
                    ow_tgt_ar_we <= cap_tgt_ar_we;
                    ow_result    <= cap_result;
                    ow_mem_fault <= 1'b0;
                    ow_sr_result <= (cap_is_ld && !cap_sel_ar) ? {rd_word, cap_lo} : cap_sr_result;
                    ow_ar_result <= (cap_is_ld &&  cap_sel_ar) ? {rd_word, cap_lo} : cap_ar_result;
                end
                default: ow_mem_fault <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_stg_mo.sv
// Directed bench for stg_mo: narrow ops, wide load/store beats, wrap, reset abort, alignment.
module tb_stg_mo;
    import stg_mo_pkg::*;

    logic              iw_clk = 1'b0;
    logic              iw_rst;
    logic [47:0]       iw_pc, iw_sr_result, iw_ar_result, iw_addr_q;
    logic [23:0]       iw_instr, iw_result;
    logic [OPC_W-1:0]  iw_opc, iw_root_opc;
    logic [GP_W-1:0]   iw_tgt_gp;
    logic [SR_W-1:0]   iw_tgt_sr;
    logic [AR_W-1:0]   iw_tgt_ar;
    logic              iw_tgt_gp_we, iw_tgt_sr_we, iw_tgt_ar_we, iw_mem_mp;
    logic [1:0]        ow_mem_we;
    logic [23:0]       ow_mem_wdata [0:1];
    logic [23:0]       iw_mem_rdata [0:1];
    logic [47:0]       ow_mem_addr_ovr, ow_pc, ow_sr_result, ow_ar_result;
    logic              ow_mem_addr_ovr_en, ow_stall, ow_mem_fault;
    logic [23:0]       ow_instr, ow_result;
    logic [OPC_W-1:0]  ow_opc, ow_root_opc;
    logic [GP_W-1:0]   ow_tgt_gp;
    logic [SR_W-1:0]   ow_tgt_sr;
    logic [AR_W-1:0]   ow_tgt_ar;
    logic              ow_tgt_gp_we, ow_tgt_sr_we, ow_tgt_ar_we;

    int checks   = 0;
    int failures = 0;

    always #5 iw_clk = ~iw_clk;

    stg_mo dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_pc(iw_pc), .iw_instr(iw_instr),
        .iw_opc(iw_opc), .iw_root_opc(iw_root_opc),
        .iw_tgt_gp(iw_tgt_gp), .iw_tgt_gp_we(iw_tgt_gp_we),
        .iw_tgt_sr(iw_tgt_sr), .iw_tgt_sr_we(iw_tgt_sr_we),
        .iw_tgt_ar(iw_tgt_ar), .iw_tgt_ar_we(iw_tgt_ar_we),
        .iw_result(iw_result), .iw_sr_result(iw_sr_result), .iw_ar_result(iw_ar_result),
        .iw_addr_q(iw_addr_q), .iw_mem_mp(iw_mem_mp),
        .ow_mem_we(ow_mem_we), .ow_mem_wdata(ow_mem_wdata), .iw_mem_rdata(iw_mem_rdata),
        .ow_mem_addr_ovr(ow_mem_addr_ovr), .ow_mem_addr_ovr_en(ow_mem_addr_ovr_en),
        .ow_stall(ow_stall), .ow_pc(ow_pc), .ow_instr(ow_instr),
        .ow_opc(ow_opc), .ow_root_opc(ow_root_opc),
        .ow_tgt_gp(ow_tgt_gp), .ow_tgt_gp_we(ow_tgt_gp_we),
        .ow_tgt_sr(ow_tgt_sr), .ow_tgt_sr_we(ow_tgt_sr_we),
        .ow_tgt_ar(ow_tgt_ar), .ow_tgt_ar_we(ow_tgt_ar_we),
        .ow_result(ow_result), .ow_sr_result(ow_sr_result), .ow_ar_result(ow_ar_result),
        .ow_mem_fault(ow_mem_fault)
    );

    task automatic tick();
        @(posedge iw_clk);
        #1;
    endtask

    task automatic idle_inputs();
        iw_pc = '0; iw_instr = '0; iw_opc = OPC_NOP; iw_root_opc = OPC_NOP;
        iw_tgt_gp = '0; iw_tgt_sr = '0; iw_tgt_ar = '0;
        iw_tgt_gp_we = 1'b0; iw_tgt_sr_we = 1'b0; iw_tgt_ar_we = 1'b0;
        iw_result = '0; iw_sr_result = '0; iw_ar_result = '0; iw_addr_q = '0;
        iw_mem_mp = 1'b0; iw_mem_rdata[0] = '0; iw_mem_rdata[1] = '0;
    endtask

    task automatic test_reset();
        iw_rst = 1'b1;
        idle_inputs();
        tick(); tick();
        checks++; if (ow_result !== 24'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", ow_result); end
        checks++; if (ow_mem_we !== 2'b00) begin failures++; $display("FAIL reset_we got=%b exp=00", ow_mem_we); end
        checks++; if (ow_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", ow_stall); end
        checks++; if (ow_mem_addr_ovr_en !== 1'b0) begin failures++; $display("FAIL reset_ovr_en got=%b exp=0", ow_mem_addr_ovr_en); end
        checks++; if ({ow_tgt_gp_we, ow_tgt_sr_we, ow_tgt_ar_we, ow_mem_fault} !== 4'b0) begin
            failures++; $display("FAIL reset_we_fault got=%b exp=0000", {ow_tgt_gp_we, ow_tgt_sr_we, ow_tgt_ar_we, ow_mem_fault}); end
        iw_rst = 1'b0;
    endtask

    task automatic test_none();
        iw_opc = OPC_NOP; iw_result = 24'h123456; iw_pc = 48'h100; iw_tgt_gp = 4'd5; iw_tgt_gp_we = 1'b1;
        #1;
        checks++; if (ow_mem_we !== 2'b00) begin failures++; $display("FAIL none_we got=%b exp=00", ow_mem_we); end
        tick();
        checks++; if (ow_result !== 24'h123456) begin failures++; $display("FAIL none_result got=%h exp=123456", ow_result); end
        checks++; if (ow_pc !== 48'h100 || ow_tgt_gp !== 4'd5 || ow_tgt_gp_we !== 1'b1) begin
            failures++; $display("FAIL none_fields pc=%h gp=%0d we=%b exp pc=100 gp=5 we=1", ow_pc, ow_tgt_gp, ow_tgt_gp_we); end
        idle_inputs();
    endtask

    task automatic test_store();
        iw_opc = OPC_ST; iw_addr_q = 48'h10; iw_mem_mp = 1'b1; iw_result = 24'hABCDEF;
        #1;
        checks++; if (ow_mem_we !== 2'b10) begin failures++; $display("FAIL st_we got=%b exp=10", ow_mem_we); end
        checks++; if (ow_mem_wdata[1] !== 24'hABCDEF) begin failures++; $display("FAIL st_wdata got=%h exp=abcdef", ow_mem_wdata[1]); end
        checks++; if (ow_stall !== 1'b0) begin failures++; $display("FAIL st_stall got=%b exp=0", ow_stall); end
        tick();
        idle_inputs();
    endtask

    task automatic test_load();
        iw_opc = OPC_LD; iw_mem_mp = 1'b0; iw_mem_rdata[0] = 24'h55AA55; iw_mem_rdata[1] = 24'h111111;
        iw_tgt_gp = 4'd3; iw_tgt_gp_we = 1'b1; iw_result = 24'h999999;
        #1;
        checks++; if (ow_mem_we !== 2'b00) begin failures++; $display("FAIL ld_we got=%b exp=00", ow_mem_we); end
        tick();
        checks++; if (ow_result !== 24'h55AA55) begin failures++; $display("FAIL ld_result got=%h exp=55aa55", ow_result); end
        checks++; if (ow_tgt_gp_we !== 1'b1 || ow_tgt_gp !== 4'd3) begin failures++; $display("FAIL ld_tgt we=%b gp=%0d exp we=1 gp=3", ow_tgt_gp_we, ow_tgt_gp); end
        idle_inputs();
    endtask

    task automatic test_wide_load();
        int stalls = 0;
        iw_opc = OPC_LDW_AR; iw_addr_q = 48'h20; iw_mem_mp = 1'b0; iw_mem_rdata[0] = 24'h000111;
        iw_tgt_ar = 2'd2; iw_tgt_ar_we = 1'b1;
        #1;
        if (ow_stall) stalls++;
        checks++; if (ow_stall !== 1'b1 || ow_mem_we !== 2'b00) begin failures++; $display("FAIL ldw_lo stall=%b we=%b exp stall=1 we=00", ow_stall, ow_mem_we); end
        tick();
        if (ow_stall) stalls++;
        checks++; if (ow_tgt_ar_we !== 1'b0) begin failures++; $display("FAIL ldw_bubble1 ar_we=%b exp=0", ow_tgt_ar_we); end
        checks++; if (ow_mem_addr_ovr_en !== 1'b1 || ow_mem_addr_ovr !== 48'h21) begin
            failures++; $display("FAIL ldw_ovr en=%b addr=%h exp en=1 addr=21", ow_mem_addr_ovr_en, ow_mem_addr_ovr); end
        iw_mem_rdata[0] = 24'h000222;
        tick();
        if (ow_stall) stalls++;
        checks++; if (ow_tgt_ar_we !== 1'b0 || ow_mem_we !== 2'b00) begin failures++; $display("FAIL ldw_bubble2 ar_we=%b we=%b exp 0/00", ow_tgt_ar_we, ow_mem_we); end
        iw_opc = OPC_NOP; iw_tgt_ar_we = 1'b0; iw_tgt_ar = 2'd0;
        checks++; if (stalls != 2) begin failures++; $display("FAIL ldw_stall_count got=%0d exp=2", stalls); end
        tick();
        checks++; if (ow_ar_result !== 48'h000222000111) begin failures++; $display("FAIL ldw_data got=%h exp=000222000111", ow_ar_result); end
        checks++; if (ow_tgt_ar_we !== 1'b1 || ow_tgt_ar !== 2'd2) begin failures++; $display("FAIL ldw_wb we=%b ar=%0d exp we=1 ar=2", ow_tgt_ar_we, ow_tgt_ar); end
        tick();
        checks++; if (ow_tgt_ar_we !== 1'b0) begin failures++; $display("FAIL ldw_once ar_we=%b exp=0", ow_tgt_ar_we); end
        idle_inputs();
    endtask

    task automatic test_wide_store_wrap();
        iw_opc = OPC_STW_SR; iw_addr_q = 48'hFFFF_FFFF_FFFF; iw_sr_result = 48'hAAAAAA_BBBBBB;
        iw_ar_result = 48'h123; iw_mem_mp = 1'b1;
        #1;
        checks++; if (ow_mem_we !== 2'b10 || ow_mem_wdata[1] !== 24'hBBBBBB || ow_stall !== 1'b1) begin
            failures++; $display("FAIL stw_lo we=%b wd=%h stall=%b exp 10/bbbbbb/1", ow_mem_we, ow_mem_wdata[1], ow_stall); end
        tick();
        checks++; if (ow_mem_addr_ovr !== 48'h0 || ow_mem_addr_ovr_en !== 1'b1 || ow_mem_we !== 2'b00) begin
            failures++; $display("FAIL stw_wrap ovr=%h en=%b we=%b exp 0/1/00", ow_mem_addr_ovr, ow_mem_addr_ovr_en, ow_mem_we); end
        tick();
        checks++; if (ow_mem_we !== 2'b10 || ow_mem_wdata[1] !== 24'hAAAAAA || ow_stall !== 1'b0) begin
            failures++; $display("FAIL stw_hi we=%b wd=%h stall=%b exp 10/aaaaaa/0", ow_mem_we, ow_mem_wdata[1], ow_stall); end
        idle_inputs();
        tick();
        checks++; if (ow_mem_we !== 2'b00 || ow_stall !== 1'b0) begin failures++; $display("FAIL stw_done we=%b stall=%b exp 00/0", ow_mem_we, ow_stall); end
    endtask

    task automatic test_reset_mid_wide();
        iw_opc = OPC_STW_AR; iw_addr_q = 48'h40; iw_ar_result = 48'h000777_000888; iw_mem_mp = 1'b0;
        #1;
        checks++; if (ow_mem_we !== 2'b01 || ow_mem_wdata[0] !== 24'h000888) begin
            failures++; $display("FAIL rstmid_lo we=%b wd=%h exp 01/000888", ow_mem_we, ow_mem_wdata[0]); end
        tick();
        iw_rst = 1'b1;
        tick();
        iw_rst = 1'b0;
        idle_inputs();
        #1;
        checks++; if (ow_stall !== 1'b0 || ow_mem_addr_ovr_en !== 1'b0 || ow_mem_we !== 2'b00) begin
            failures++; $display("FAIL rstmid_pass stall=%b en=%b we=%b exp 0/0/00", ow_stall, ow_mem_addr_ovr_en, ow_mem_we); end
        tick();
        checks++; if (ow_mem_we !== 2'b00 || ow_tgt_ar_we !== 1'b0) begin
            failures++; $display("FAIL rstmid_nohi we=%b ar_we=%b exp 00/0", ow_mem_we, ow_tgt_ar_we); end
    endtask

    task automatic test_misalign();
        iw_opc = OPC_LDW_AR; iw_addr_q = 48'h21; iw_mem_mp = 1'b0; iw_mem_rdata[0] = 24'h000333;
        iw_tgt_ar = 2'd1; iw_tgt_ar_we = 1'b1;
        #1;
`ifdef MO_ALIGN_CHECK_EN
        checks++; if (ow_stall !== 1'b0 || ow_mem_we !== 2'b00) begin failures++; $display("FAIL mis_nostall stall=%b we=%b exp 0/00", ow_stall, ow_mem_we); end
        tick();
        checks++; if (ow_mem_fault !== 1'b1 || ow_tgt_ar_we !== 1'b0) begin failures++; $display("FAIL mis_fault fault=%b ar_we=%b exp 1/0", ow_mem_fault, ow_tgt_ar_we); end
        idle_inputs();
        tick();
        checks++; if (ow_mem_fault !== 1'b0) begin failures++; $display("FAIL mis_clear fault=%b exp=0", ow_mem_fault); end
`else
        checks++; if (ow_stall !== 1'b1) begin failures++; $display("FAIL mis_stall stall=%b exp=1", ow_stall); end
        tick();
        checks++; if (ow_mem_fault !== 1'b0 || ow_mem_addr_ovr !== 48'h22) begin failures++; $display("FAIL mis_ovr fault=%b ovr=%h exp 0/22", ow_mem_fault, ow_mem_addr_ovr); end
        iw_mem_rdata[0] = 24'h000444;
        tick();
        iw_opc = OPC_NOP; iw_tgt_ar_we = 1'b0;
        tick();
        checks++; if (ow_ar_result !== 48'h000444000333 || ow_tgt_ar_we !== 1'b1) begin
            failures++; $display("FAIL mis_done ar=%h we=%b exp 000444000333/1", ow_ar_result, ow_tgt_ar_we); end
        idle_inputs();
        tick();
`endif
    endtask

    task automatic test_back_to_back();
        iw_opc = OPC_ST; iw_mem_mp = 1'b0; iw_result = 24'h0F0F0F;
        #1;
        checks++; if (ow_mem_we !== 2'b01 || ow_mem_wdata[0] !== 24'h0F0F0F) begin
            failures++; $display("FAIL b2b_st we=%b wd=%h exp 01/0f0f0f", ow_mem_we, ow_mem_wdata[0]); end
        tick();
        iw_opc = OPC_LD; iw_mem_mp = 1'b1; iw_mem_rdata[1] = 24'h777777; iw_mem_rdata[0] = 24'h222222;
        iw_tgt_gp = 4'd9; iw_tgt_gp_we = 1'b1;
        #1;
        checks++; if (ow_mem_we !== 2'b00) begin failures++; $display("FAIL b2b_ld_we we=%b exp 00", ow_mem_we); end
        tick();
        checks++; if (ow_result !== 24'h777777 || ow_tgt_gp !== 4'd9) begin
            failures++; $display("FAIL b2b_ld result=%h gp=%0d exp 777777/9", ow_result, ow_tgt_gp); end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_none();
        test_store();
        test_load();
        test_wide_load();
        test_wide_store_wrap();
        test_reset_mid_wide();
        test_misalign();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
